latency_probe: RTL
==================

// Module: latency_probe
// PURPOSE
//  Stimulus-and-response companion for our d->q pipeline DUTs. Drives a DUT's
//  d input, watches its q output and measures the d->q latency in clocks
//  (0 = combinational, 1 = one flop, 2 = two flops, ...).
//  It then checks that a stream of data passes through the DUT intact.
//  Sits in the lab bench / self-test wrapper next to the DUT under measurement.
// PARAMETERS
//  WIDTH    8   data width of dut_d / dut_q
//  MAX_LAT  15  largest latency searched; also the FLUSH length minus 1
//  NCHK     16  number of CHECK-phase cycles
//  MARK     8'hA5  probe word; BASE = ~MARK (8'h5A) is the flush word
// PORTS
//  clk      in   1      single clock, all state on posedge
//  rst      in   1      synchronous, active-high reset
//  start    in   1      begin a measurement; sampled only in IDLE
//  busy     out  1      1 in every state except IDLE
//  done     out  1      one-cycle pulse in DONE
//  lat      out  LW     measured latency; LW = $clog2(MAX_LAT+1)
//  timeout  out  1      MARK never seen at dut_q within MAX_LAT+1 PROBE cycles
//  err      out  1      sticky: any CHECK-phase mismatch
//  dut_d    out  WIDTH  registered drive to DUT d
//  dut_q    in   WIDTH  DUT q, sampled as-is (may be combinational from dut_d)
// BEHAVIOUR
//  Reset values:
//   - state=IDLE; dut_d, lat, timeout, err, busy, done, counters = 0.
//   - History shift register hist[0..MAX_LAT] = 0.
//  Reset mid-operation: rst wins over everything. The next cycle is IDLE with all reset values.
//  IDLE:
//   - dut_d holds its value.
//   - start=1 -> FLUSH; clears lat/timeout/err; dut_d<=BASE; cnt<=0.
//  FLUSH: drive BASE for exactly MAX_LAT+1 cycles, so any pipeline <= MAX_LAT holds BASE. Then -> PROBE, dut_d<=MARK, cnt<=0.
//  PROBE:
//   - dut_d=MARK; cnt counts cycles since PROBE entry, starting at 0.
//   - dut_q==MARK in cycle cnt: lat<=cnt; -> CHECK; dut_d<=8'h01; cnt<=0.
//   - No match and cnt==MAX_LAT: timeout<=1; lat<=0; -> DONE (CHECK skipped).
//  CHECK (NCHK cycles):
//   - dut_d is an incrementing pattern 01,02,..; wraps modulo 2^WIDTH.
//   - hist shifts each cycle: hist[0]=current dut_d, hist[k]=dut_d k cycles ago. hist also shifts in FLUSH/PROBE.
//   - Each cycle compare dut_q against hist[lat]; mismatch -> err<=1 (sticky).
//   - The first lat CHECK cycles therefore expect MARK.
//   - After cycle NCHK-1 -> DONE.
//  DONE:
//   - done=1 for exactly one cycle; busy=1; -> IDLE.
//   - start is ignored here and everywhere except IDLE.
//  lat/timeout/err hold from DONE until the next accepted start or rst.
//  Timing: start sampled at edge 0 -> FLUSH cycles 1..MAX_LAT+1 -> PROBE from cycle MAX_LAT+2.
//  With defaults, done is in cycle 34+lat; on timeout, done is in cycle 33.
//  Compare is equality over full WIDTH; X on dut_q counts as a mismatch.
// TESTING
//  1. DUT q=d (wire): start -> done at cycle 34; lat=0, timeout=0, err=0.
//  2. DUT = one posedge flop: start -> done at cycle 35; lat=1, err=0.
//  3. DUT = two-flop chain: start -> done at cycle 36; lat=2, err=0; dut_d runs 01..10 in CHECK.
//  4. DUT q tied to 8'h00: start -> done at cycle 33; timeout=1, lat=0, err=0.
//  5. One-flop DUT, bit 0 of dut_q flipped in the 5th CHECK cycle: lat=1, err=1 at done.
//  6. rst=1 mid-CHECK: next cycle busy=0, dut_d=0, lat/err=0; a restart then gives the case-2 result.

Source files
------------

// File: rtl/latency_probe.sv
// latency_probe: drives a d->q DUT, measures its latency in clocks, then streams a counting pattern and checks it arrives intact
module latency_probe #(
  parameter int WIDTH = 8,
  parameter int MAX_LAT = 15,
  parameter int NCHK = 16,
  parameter logic [WIDTH-1:0] MARK = 8'hA5,
  parameter int LW = $clog2(MAX_LAT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [LW-1:0]    lat,
  output logic             timeout,
  output logic             err,
  output logic [WIDTH-1:0] dut_d,
  input  logic [WIDTH-1:0] dut_q
);
  localparam int CW = (LW > $clog2(NCHK)) ? LW : $clog2(NCHK);
  localparam logic [WIDTH-1:0] BASE = ~MARK;
  typedef enum logic [2:0] {S_IDLE, S_FLUSH, S_PROBE, S_CHECK, S_DONE} state_t;
  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [LW-1:0]    r_lat;
  logic             r_to, r_err, r_busy, r_done;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_hist [1:MAX_LAT];
  logic [WIDTH-1:0] w_hist [0:MAX_LAT];
  logic [WIDTH-1:0] w_exp;
  // w_hist[k] is the word driven k cycles ago; slot 0 is the word on dut_d now
  always_comb begin
    w_hist[0] = r_d;
    for (int k = 1; k <= MAX_LAT; k++) w_hist[k] = r_hist[k];
    w_exp = w_hist[r_lat];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt <= '0;
      r_lat <= '0;
      r_to <= 1'b0;
      r_err <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_d <= '0;
      for (int k = 1; k <= MAX_LAT; k++) r_hist[k] <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_state inside {S_FLUSH, S_PROBE, S_CHECK}) begin
        r_hist[1] <= r_d;
        for (int k = 2; k <= MAX_LAT; k++) r_hist[k] <= r_hist[k-1];
      end
      case (r_state)
        S_IDLE: if (start) begin
          r_state <= S_FLUSH;
          r_busy <= 1'b1;
          r_lat <= '0;
          r_to <= 1'b0;
          r_err <= 1'b0;
          r_d <= BASE;
          r_cnt <= '0;
        end
        S_FLUSH: if (r_cnt == CW'(MAX_LAT)) begin
          r_state <= S_PROBE;
          r_d <= MARK;
          r_cnt <= '0;
        end else r_cnt <= r_cnt + 1'b1;
        S_PROBE: if (dut_q == MARK) begin
          r_lat <= r_cnt[LW-1:0];
          r_state <= S_CHECK;
          r_d <= WIDTH'(1);
          r_cnt <= '0;
        end else if (r_cnt == CW'(MAX_LAT)) begin
          r_to <= 1'b1;
          r_lat <= '0;
          r_state <= S_DONE;
          r_done <= 1'b1;
        end else r_cnt <= r_cnt + 1'b1;
        S_CHECK: begin
          // written as if/else so an unknown dut_q falls through to the error branch
          if (dut_q == w_exp) r_err <= r_err;
          else r_err <= 1'b1;
          r_d <= r_d + WIDTH'(1);
          if (r_cnt == CW'(NCHK - 1)) begin
            r_state <= S_DONE;
            r_done <= 1'b1;
          end else r_cnt <= r_cnt + 1'b1;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign busy = r_busy;
  assign done = r_done;
  assign lat = r_lat;
  assign timeout = r_to;
  assign err = r_err;
  assign dut_d = r_d;
endmodule
